adc_frame_receiver: RTL and testbench
=====================================

# adc_frame_receiver

Serial-to-parallel receiver for the ADC sample stream. The ADC front end's parallel-load shift register emits each 10-bit conversion MSB-first on a serial line, advanced by a per-clock shift strobe. This block reassembles those bits into a sample word and tags it with the channel that was selected when the frame started. It presents the word on a valid/ready output, keeps a last-sample register per channel, and flags overrun and truncated frames.

## Interface
Parameters:
- WIDTH, 10, bits per sample frame
- MSB_FIRST, 1, 1 = first received bit lands in bit WIDTH-1; 0 = lands in bit 0

Ports:
- clk  input  1  system clock; all state changes on rising edge
- restart  input  1  asynchronous, active-high reset
- frame_start  input  1  one-cycle strobe; the transmitter has just parallel-loaded a new word
- channel_sel  input  1  ADC channel (0 = analog_one, 1 = analog_two), sampled on frame_start
- shift_edge  input  1  shift strobe; serial_in is valid on every clk cycle where this is 1
- serial_in  input  1  serial data from the shift register output
- sample_out  output  WIDTH  assembled sample word
- sample_channel  output  1  channel tag of sample_out
- sample_valid  output  1  sample_out and sample_channel hold an undelivered word
- sample_ready  input  1  consumer accepts the word when valid && ready
- last_one  output  WIDTH  most recent completed frame on channel 0
- last_two  output  WIDTH  most recent completed frame on channel 1
- overrun  output  1  sticky; a completed frame was dropped
- frame_err  output  1  one-cycle pulse; a frame was truncated by a new frame_start

## Operation
FSM states:
- IDLE: wait for frame_start.
- SHIFT: capture bits.
- COMMIT: single cycle; write the result to the output stage.

Transitions:
- IDLE + frame_start -> SHIFT. On entry: latch channel_sel, bit_cnt <= 0, clear shift register.
- In SHIFT, each shift_edge cycle shifts serial_in in and increments bit_cnt.
- When the WIDTH-th bit is captured -> COMMIT.
- COMMIT -> IDLE. If frame_start is asserted in the COMMIT cycle, go to SHIFT instead.

Arbitration and boundary cases:
- frame_start in SHIFT with bit_cnt > 0: pulse frame_err, discard partial data, restart the frame with a newly latched channel_sel.
- frame_start in SHIFT with bit_cnt == 0: restart silently.
- frame_start and shift_edge in the same cycle: frame_start wins and that bit is not captured. The transmitter loads on that cycle, so the bit is stale.
- shift_edge in IDLE or COMMIT is ignored.

COMMIT behaviour:
- last_one or last_two (selected by the latched channel) is always updated.
- The output stage is loaded if it is empty (sample_valid = 0) or is being drained this cycle (sample_valid && sample_ready).
- Otherwise the new word is dropped from the output stage and overrun is set. The old word is kept.

Handshake:
- sample_valid stays 1 until a cycle with sample_ready = 1.
- sample_out and sample_channel are stable while valid.
- overrun clears only on restart.

Counter: bit_cnt is ceil(log2(WIDTH+1)) bits and never wraps. COMMIT is entered at count == WIDTH.

## Timing
- Reset values: sample_out = 0, sample_channel = 0, sample_valid = 0, last_one = 0, last_two = 0, overrun = 0, frame_err = 0, FSM = IDLE, bit_cnt = 0.
- restart asserted mid-frame aborts immediately. No frame_err and no commit.
- Latency: sample_valid rises 2 clk cycles after the rising edge that captured the final bit.
  - Edge N captures the final bit.
  - Edge N+1 is COMMIT.
  - sample_valid is visible after edge N+1 and sampled high at edge N+2.
- frame_err is asserted for exactly the cycle after the offending frame_start edge.
- Minimum frame spacing is WIDTH shift cycles plus 1. Back-to-back frames (frame_start in the COMMIT cycle) lose no bits.

## Structure
- Shared package adc_pkg: SAMPLE_WIDTH = 10, CH_ONE = 0, CH_TWO = 1, and the FSM state enum (IDLE, SHIFT, COMMIT).
- The ADC and the transmit shift register also use this package.
- One natural sub-module, sample_out_stage: the output register plus valid/ready/overrun logic.
  - Inputs: load strobe, data, channel.
  - Reused later for the parallel readout path.

## Test plan
- Reset, then frame_start with channel_sel = 0, then ten shift_edge cycles with serial_in = 1 -> sample_out = 0x3FF, sample_channel = 0, sample_valid = 1, last_one = 0x3FF, last_two = 0.
- Channel 1 frame with bits 1010101010, sample_ready held 1 -> sample_out = 0x2AA, sample_channel = 1, last_two = 0x2AA, valid for one cycle.
- Two complete frames (0x000 then 0x3FF on channel 0) with sample_ready = 0 -> sample_out stays 0x000, overrun = 1, last_one = 0x3FF.
- frame_start after 4 bits -> frame_err pulses once. The following full frame 0x155 is delivered correctly.
- frame_start coincident with shift_edge and serial_in = 1, followed by ten bits of 0 -> sample_out = 0x000 (coincident bit ignored).
- restart asserted at bit 5 of a frame -> all outputs return to reset values, no valid, no frame_err. The next frame is received normally.

Source files
------------

// File: rtl/adc_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : adc_pkg
// Brief  : Shared ADC constants and receiver FSM state encoding.
// Rev    : 1.0  initial release
// ============================================================================
package adc_pkg;

    localparam int   SAMPLE_WIDTH = 10;
    localparam logic CH_ONE       = 1'b0;
    localparam logic CH_TWO       = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sample_out_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : sample_out_stage
// Brief  : Single-entry valid/ready output register with sticky overrun flag.
// Rev    : 1.0  initial release
// ============================================================================
module sample_out_stage #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_channel,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             channel,
    output logic             valid,
    output logic             overrun
);

    logic w_accept;

    // Space is available when empty or when the held word drains this cycle.
    assign w_accept = !valid || ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data    <= '0;
            channel <= 1'b0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else if (load) begin
            if (w_accept) begin
                data    <= load_data;
                channel <= load_channel;
                valid   <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_frame_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : adc_frame_receiver
// Brief  : Reassembles serial ADC frames into channel-tagged sample words.
// Rev    : 1.0  initial release
// ============================================================================
module adc_frame_receiver
    import adc_pkg::*;
#(
    parameter int WIDTH     = SAMPLE_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             restart,
    input  logic             frame_start,
    input  logic             channel_sel,
    input  logic             shift_edge,
    input  logic             serial_in,
    output logic [WIDTH-1:0] sample_out,
    output logic             sample_channel,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic [WIDTH-1:0] last_one,
    output logic [WIDTH-1:0] last_two,
    output logic             overrun,
    output logic             frame_err
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_next;
    logic             r_channel;
    logic             r_frame_err;
    logic             w_start;
    logic             w_shift;
    logic             w_commit;
    logic             w_err;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shreg_next = {r_shreg[WIDTH-2:0], serial_in};
        end else begin : g_lsb_first
            assign w_shreg_next = {serial_in, r_shreg[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge restart) begin
        if (restart) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // frame_start always takes priority over a coincident shift strobe.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_shift      = 1'b0;
        w_commit     = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            IDLE: begin
                if (frame_start) begin
                    w_start      = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (frame_start) begin
                    w_start = 1'b1;
                    w_err   = (r_bit_cnt != '0);
                end else if (shift_edge) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == CNT_W'(WIDTH - 1)) begin
                        w_state_next = COMMIT;
                    end
                end
            end
            COMMIT: begin
                w_commit = 1'b1;
                if (frame_start) begin
                    w_start      = 1'b1;
                    w_state_next = SHIFT;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge restart) begin
        if (restart) begin
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_channel   <= CH_ONE;
            r_frame_err <= 1'b0;
            last_one    <= '0;
            last_two    <= '0;
        end else begin
            r_frame_err <= w_err;
            if (w_start) begin
                r_bit_cnt <= '0;
                r_shreg   <= '0;
                r_channel <= channel_sel;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                r_shreg   <= w_shreg_next;
            end
            if (w_commit) begin
                if (r_channel == CH_ONE) begin
                    last_one <= r_shreg;
                end else begin
                    last_two <= r_shreg;
                end
            end
        end
    end

    assign frame_err = r_frame_err;

    sample_out_stage #(
        .WIDTH(WIDTH)
    ) u_out_stage (
        .clk          (clk),
        .rst          (restart),
        .load         (w_commit),
        .load_data    (r_shreg),
        .load_channel (r_channel),
        .ready        (sample_ready),
        .data         (sample_out),
        .channel      (sample_channel),
        .valid        (sample_valid),
        .overrun      (overrun)
    );

endmodule
`default_nettype wire

// File: tb/tb_adc_frame_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_adc_frame_receiver
// Brief  : Directed self-checking bench with a delivered-word scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
module tb_adc_frame_receiver;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         restart;
    logic         frame_start;
    logic         channel_sel;
    logic         shift_edge;
    logic         serial_in;
    logic [W-1:0] sample_out;
    logic         sample_channel;
    logic         sample_valid;
    logic         sample_ready;
    logic [W-1:0] last_one;
    logic [W-1:0] last_two;
    logic         overrun;
    logic         frame_err;

    int compared   = 0;
    int mismatched = 0;

    logic [W:0] sb_q[$];

    adc_frame_receiver #(
        .WIDTH     (W),
        .MSB_FIRST (1'b1)
    ) dut (
        .clk            (clk),
        .restart        (restart),
        .frame_start    (frame_start),
        .channel_sel    (channel_sel),
        .shift_edge     (shift_edge),
        .serial_in      (serial_in),
        .sample_out     (sample_out),
        .sample_channel (sample_channel),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .last_one       (last_one),
        .last_two       (last_two),
        .overrun        (overrun),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;

    // Words are popped at the negedge preceding the accepting posedge.
    always @(negedge clk) begin
        if (!restart && sample_valid && sample_ready) begin
            logic [W:0] exp_word;
            compared++;
            assert (sb_q.size() != 0) else begin
                mismatched++;
                $error("FAIL sb_underflow observed=0x%0h expected=none", {sample_channel, sample_out});
            end
            if (sb_q.size() != 0) begin
                exp_word = sb_q.pop_front();
                compared++;
                assert ({sample_channel, sample_out} === exp_word) else begin
                    mismatched++;
                    $error("FAIL sb_word observed=0x%0h expected=0x%0h", {sample_channel, sample_out}, exp_word);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out"},   16'(sample_out),     16'h0);
        check({tag, "_ch"},    16'(sample_channel), 16'h0);
        check({tag, "_valid"}, 16'(sample_valid),   16'h0);
        check({tag, "_one"},   16'(last_one),       16'h0);
        check({tag, "_two"},   16'(last_two),       16'h0);
        check({tag, "_ovr"},   16'(overrun),        16'h0);
        check({tag, "_ferr"},  16'(frame_err),      16'h0);
    endtask

    task automatic start_frame(input logic ch);
        frame_start = 1'b1;
        channel_sel = ch;
        shift_edge  = 1'b0;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send_bits(input logic [W-1:0] word, input int n);
        for (int i = 0; i < n; i++) begin
            shift_edge = 1'b1;
            serial_in  = word[W-1-i];
            tick();
        end
        shift_edge = 1'b0;
        serial_in  = 1'b0;
    endtask

    initial begin
        restart      = 1'b1;
        frame_start  = 1'b0;
        channel_sel  = 1'b0;
        shift_edge   = 1'b0;
        serial_in    = 1'b0;
        sample_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check_reset_outputs("reset");
        tick();
        restart = 1'b0;

        // Channel 0, all ones, consumer stalled.
        start_frame(1'b0);
        sb_q.push_back({1'b0, 10'h3FF});
        send_bits(10'h3FF, W);
        @(negedge clk);
        check("t1_latency_valid", 16'(sample_valid), 16'h0);
        tick();
        @(negedge clk);
        check("t1_valid", 16'(sample_valid),   16'h1);
        check("t1_out",   16'(sample_out),     16'h3FF);
        check("t1_ch",    16'(sample_channel), 16'h0);
        check("t1_one",   16'(last_one),       16'h3FF);
        check("t1_two",   16'(last_two),       16'h0);
        tick();
        sample_ready = 1'b1;
        tick();
        @(negedge clk);
        check("t1_drained", 16'(sample_valid), 16'h0);

        // Channel 1 alternating pattern, consumer always ready.
        start_frame(1'b1);
        sb_q.push_back({1'b1, 10'h2AA});
        send_bits(10'h2AA, W);
        tick();
        @(negedge clk);
        check("t2_valid", 16'(sample_valid),   16'h1);
        check("t2_out",   16'(sample_out),     16'h2AA);
        check("t2_ch",    16'(sample_channel), 16'h1);
        check("t2_two",   16'(last_two),       16'h2AA);
        tick();
        @(negedge clk);
        check("t2_one_cycle", 16'(sample_valid), 16'h0);

        // Back-to-back frames while stalled: second word overruns.
        sample_ready = 1'b0;
        start_frame(1'b0);
        sb_q.push_back({1'b0, 10'h000});
        send_bits(10'h000, W);
        start_frame(1'b0);
        send_bits(10'h3FF, W);
        tick();
        @(negedge clk);
        check("t3_out",   16'(sample_out),   16'h000);
        check("t3_valid", 16'(sample_valid), 16'h1);
        check("t3_ovr",   16'(overrun),      16'h1);
        check("t3_one",   16'(last_one),     16'h3FF);
        tick();
        sample_ready = 1'b1;
        tick();
        @(negedge clk);
        check("t3_drained", 16'(sample_valid), 16'h0);

        // Truncated frame followed by a clean channel 1 frame.
        start_frame(1'b0);
        send_bits(10'h3FF, 4);
        start_frame(1'b1);
        @(negedge clk);
        check("t4_ferr_pulse", 16'(frame_err), 16'h1);
        tick();
        @(negedge clk);
        check("t4_ferr_clear", 16'(frame_err), 16'h0);
        sb_q.push_back({1'b1, 10'h155});
        send_bits(10'h155, W);
        tick();
        @(negedge clk);
        check("t4_out", 16'(sample_out),     16'h155);
        check("t4_ch",  16'(sample_channel), 16'h1);
        check("t4_two", 16'(last_two),       16'h155);
        check("t4_one", 16'(last_one),       16'h3FF);

        // Coincident frame_start and shift_edge: the stale bit is dropped.
        start_frame(1'b0);
        frame_start = 1'b1;
        channel_sel = 1'b0;
        shift_edge  = 1'b1;
        serial_in   = 1'b1;
        tick();
        frame_start = 1'b0;
        shift_edge  = 1'b0;
        serial_in   = 1'b0;
        @(negedge clk);
        check("t5_silent_restart", 16'(frame_err), 16'h0);
        sb_q.push_back({1'b0, 10'h000});
        send_bits(10'h000, W);
        tick();
        @(negedge clk);
        check("t5_out",   16'(sample_out),   16'h000);
        check("t5_valid", 16'(sample_valid), 16'h1);
        check("t5_one",   16'(last_one),     16'h000);
        check("t5_ovr_sticky", 16'(overrun), 16'h1);
        tick();

        // Restart mid-frame aborts everything.
        start_frame(1'b1);
        send_bits(10'h3C3, 5);
        restart = 1'b1;
        @(negedge clk);
        check_reset_outputs("t6_reset");
        tick();
        restart = 1'b0;
        @(negedge clk);
        check("t6_ferr", 16'(frame_err),    16'h0);
        check("t6_valid", 16'(sample_valid), 16'h0);
        start_frame(1'b0);
        sb_q.push_back({1'b0, 10'h1A5});
        send_bits(10'h1A5, W);
        tick();
        @(negedge clk);
        check("t6_out",   16'(sample_out), 16'h1A5);
        check("t6_one",   16'(last_one),   16'h1A5);
        check("t6_two",   16'(last_two),   16'h0);
        tick();
        tick();
        @(negedge clk);
        check("sb_queue_empty", 16'(sb_q.size()), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
